// File: rtl/snn_fixed_pkg.sv
// Shared QS2.13 fixed-point definitions for the SNN layers: word sizes,
// saturation limits, saturating narrow helper and the stream receiver states.
package snn_fixed_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 13;
  localparam int WIDE_WIDTH = 2 * DATA_WIDTH;

  localparam logic signed [DATA_WIDTH-1:0] QS_MAX = 16'sh7FFF;
  localparam logic signed [DATA_WIDTH-1:0] QS_MIN = 16'sh8000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } lif_state_t;

  // Clamp a wide signed intermediate into the QS2.13 range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_to_data(
    input logic signed [WIDE_WIDTH-1:0] v
  );
    logic signed [WIDE_WIDTH-1:0] hi_s;
    logic signed [WIDE_WIDTH-1:0] lo_s;
    logic signed [DATA_WIDTH-1:0] r_s;
    hi_s = {{(WIDE_WIDTH-DATA_WIDTH){QS_MAX[DATA_WIDTH-1]}}, QS_MAX};
    lo_s = {{(WIDE_WIDTH-DATA_WIDTH){QS_MIN[DATA_WIDTH-1]}}, QS_MIN};
    if (v > hi_s) begin
      r_s = QS_MAX;
    end else if (v < lo_s) begin
      r_s = QS_MIN;
    end else begin
      r_s = v[DATA_WIDTH-1:0];
    end
    return r_s;
  endfunction

endpackage

// File: rtl/lif_stream_layer_if.sv
// Serial current stream from the fully connected layer: one
// (current, neuron index) beat per cycle, no backpressure.
interface lif_stream_layer_if #(
  parameter int NUM_NEURONS = 16,
  parameter int DATA_WIDTH  = 16
);
  logic signed [DATA_WIDTH-1:0]         in_current;
  logic        [$clog2(NUM_NEURONS)-1:0] in_idx;
  logic                                  in_valid;
  logic                                  in_last;

  modport master (output in_current, output in_idx, output in_valid, output in_last);
  modport slave  (input  in_current, input  in_idx, input  in_valid, input  in_last);
endinterface

// File: rtl/lif_stream_layer_update.sv
// Combinational leaky integrate-and-fire update of one membrane, shared
// by neuron layers: decay, integrate, saturate, fire with reset-by-subtraction.
module lif_update
  import snn_fixed_pkg::*;
(
  input  logic signed [DATA_WIDTH-1:0] mem,
  input  logic signed [DATA_WIDTH-1:0] current,
  input  logic signed [DATA_WIDTH-1:0] beta,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  output logic signed [DATA_WIDTH-1:0] mem_next,
  output logic                         spike
);

  logic signed [WIDE_WIDTH-1:0] prod_s;
  logic signed [WIDE_WIDTH-1:0] decay_s;
  logic signed [WIDE_WIDTH-1:0] sum_s;
  logic signed [DATA_WIDTH-1:0] sat_s;

  // Arithmetic shift floors the decayed membrane; the wide sum cannot wrap.
  always_comb begin
    prod_s  = mem * beta;
    decay_s = prod_s >>> FRAC_BITS;
    sum_s   = decay_s + {{(WIDE_WIDTH-DATA_WIDTH){current[DATA_WIDTH-1]}}, current};
    sat_s   = sat_to_data(sum_s);
    if (sat_s >= threshold) begin
      spike    = 1'b1;
      mem_next = sat_s - threshold;
    end else begin
      spike    = 1'b0;
      mem_next = sat_s;
    end
  end

endmodule

// File: rtl/lif_stream_layer.sv
// LIF layer fed by a serial current stream; publishes a registered spike vector
// per timestep. Define LIF_SPIKE_COUNT_EN to add the spike_count output.
module lif_stream_layer
  import snn_fixed_pkg::*;
#(
  parameter int                           NUM_NEURONS = 16,
  parameter logic signed [DATA_WIDTH-1:0] BETA        = 16'sh1CCD,
  parameter logic signed [DATA_WIDTH-1:0] THRESHOLD   = 16'sh2000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_state,
  lif_stream_layer_if.slave      s_in,
  output logic [NUM_NEURONS-1:0] spikes,
  output logic                   spikes_valid,
  output logic                   busy,
`ifdef LIF_SPIKE_COUNT_EN
  output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count,
`endif
  output logic                   seq_error
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] NUM_N_C = CNT_W'(NUM_NEURONS);

  logic signed [DATA_WIDTH-1:0] mem_r [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       shadow_r;
  logic [NUM_NEURONS-1:0]       shadow_next_s;
  logic [CNT_W-1:0]             cnt_r;
  logic [CNT_W-1:0]             cnt_inc_s;
  logic [CNT_W-1:0]             idx_ext_s;
  logic                         idx_ok_s;
  logic                         beat_s;
  logic                         wr_s;
  logic                         err_s;
  logic signed [DATA_WIDTH-1:0] mem_rd_s;
  logic signed [DATA_WIDTH-1:0] mem_next_s;
  logic                         spike_s;
  lif_state_t                   state_r;
  lif_state_t                   state_s;

  lif_update u_update (
    .mem       (mem_rd_s),
    .current   (s_in.in_current),
    .beta      (BETA),
    .threshold (THRESHOLD),
    .mem_next  (mem_next_s),
    .spike     (spike_s)
  );

  // Beat qualification, membrane read and protocol checks; clear_state drops the beat.
  always_comb begin
    idx_ext_s = {1'b0, s_in.in_idx};
    idx_ok_s  = (idx_ext_s < NUM_N_C);
    beat_s    = s_in.in_valid & ~clear_state;
    wr_s      = beat_s & idx_ok_s;
    cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    if (idx_ok_s) begin
      mem_rd_s = mem_r[s_in.in_idx];
    end else begin
      mem_rd_s = '0;
    end
    shadow_next_s = shadow_r;
    if (wr_s) begin
      shadow_next_s[s_in.in_idx] = spike_s;
    end else begin
      shadow_next_s = shadow_r;
    end
    err_s = beat_s & ((idx_ext_s != cnt_r) | ~idx_ok_s |
                      (s_in.in_last & (cnt_inc_s != NUM_N_C)));
  end

  // Next-state logic for the timestep receiver.
  always_comb begin
    state_s = state_r;
    if (clear_state) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (beat_s && !s_in.in_last) state_s = RECV; else state_s = IDLE;
        RECV:    if (beat_s && s_in.in_last)  state_s = IDLE; else state_s = RECV;
        default: state_s = IDLE;
      endcase
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Membrane register file, written at the beat's neuron index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) mem_r[i] <= '0;
    end else if (clear_state) begin
      for (int i = 0; i < NUM_NEURONS; i++) mem_r[i] <= '0;
    end else if (wr_s) begin
      mem_r[s_in.in_idx] <= mem_next_s;
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [$clog2(NUM_NEURONS+1)-1:0] pop_s;

  // Popcount of the vector about to be published.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      pop_s = pop_s + {{($clog2(NUM_NEURONS+1)-1){1'b0}}, shadow_next_s[i]};
    end
  end

  // Spike count published together with the spike vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_count <= '0;
    end else if (!clear_state && beat_s && s_in.in_last) begin
      spike_count <= pop_s;
    end
  end
`endif

  // Shadow accumulation, beat counter, publication and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r     <= '0;
      cnt_r        <= '0;
      spikes       <= '0;
      spikes_valid <= 1'b0;
      seq_error    <= 1'b0;
    end else if (clear_state) begin
      shadow_r     <= '0;
      cnt_r        <= '0;
      spikes_valid <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      spikes_valid <= 1'b0;
      if (err_s) seq_error <= 1'b1;
      if (beat_s) begin
        if (s_in.in_last) begin
          spikes       <= shadow_next_s;
          spikes_valid <= 1'b1;
          shadow_r     <= '0;
          cnt_r        <= '0;
        end else begin
          shadow_r <= shadow_next_s;
          cnt_r    <= cnt_inc_s;
        end
      end
    end
  end

  assign busy = (state_r == RECV);

endmodule

// File: tb/tb_lif_stream_layer.sv
// Scoreboard bench for lif_stream_layer: directed steps push expected spike
// vectors; a negedge monitor pops and compares each spikes_valid pulse.
module tb_lif_stream_layer;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear_state;
  logic [N-1:0] spikes;
  logic         spikes_valid;
  logic         busy;
  logic         seq_error;
`ifdef LIF_SPIKE_COUNT_EN
  logic [4:0]   spike_count;
`endif

  lif_stream_layer_if #(.NUM_NEURONS(N), .DATA_WIDTH(16)) bus ();

  lif_stream_layer #(.NUM_NEURONS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear_state  (clear_state),
    .s_in         (bus),
    .spikes       (spikes),
    .spikes_valid (spikes_valid),
    .busy         (busy),
`ifdef LIF_SPIKE_COUNT_EN
    .spike_count  (spike_count),
`endif
    .seq_error    (seq_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] spk;
    int           at;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] cur_tab [N];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every spikes_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (spikes_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_spikes_valid: got pulse at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("spikes", int'(spikes), int'(e.spk));
        check("spikes_latency", cyc, e.at);
`ifdef LIF_SPIKE_COUNT_EN
        check("spike_count", int'(spike_count), $countones(e.spk));
`endif
      end
    end
  end

  task automatic beat(input logic [15:0] cur, input int idx, input logic last,
                      input logic [N-1:0] exp_spk);
    bus.in_current = cur;
    bus.in_idx     = idx[3:0];
    bus.in_valid   = 1'b1;
    bus.in_last    = last;
    if (last) exp_q.push_back('{exp_spk, cyc + 1});
    @(negedge clk);
  endtask

  task automatic run_step(input logic [N-1:0] exp_spk);
    for (int i = 0; i < N; i++) beat(cur_tab[i], i, (i == N - 1), exp_spk);
  endtask

  task automatic stop();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < N; i++) cur_tab[i] = v;
  endtask

  task automatic do_clear();
    stop();
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
  endtask

  task automatic check_mem(input string name, input int i, input int exp);
    check(name, int'(dut.mem_r[i]), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_state = 1'b0;
    bus.in_current = '0;
    bus.in_idx = '0;
    stop();
    repeat (2) @(negedge clk);
    check("rst_spikes", int'(spikes), 0);
    check("rst_valid", int'(spikes_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_seq_error", int'(seq_error), 0);
    reset = 1'b0;
    @(negedge clk);

    // Three uniform steps: 4096, 7782, then all fire leaving 2907.
    fill(16'h1000);
    run_step(16'h0000);
    stop();
    check_mem("s1_mem0", 0, 4096);
    check_mem("s1_mem15", 15, 4096);
    check("s1_busy", int'(busy), 0);
    run_step(16'h0000);
    check_mem("s2_mem7", 7, 7782);
    run_step(16'hFFFF);
    stop();
    check_mem("s3_mem0", 0, 2907);
    @(negedge clk);
    check("s3_valid_one_cycle", int'(spikes_valid), 0);
    check("s3_spikes_hold", int'(spikes), 16'hFFFF);
    check("s3_seq_error", int'(seq_error), 0);

    // Single strong beat at neuron 3, then back-to-back silent step.
    do_clear();
    fill(16'h0000);
    cur_tab[3] = 16'h2000;
    run_step(16'h0008);
    check_mem("sc2_mem3", 3, 0);
    fill(16'h0000);
    run_step(16'h0000);
    stop();
    check_mem("sc2b_mem3", 3, 0);

    // Saturation at both ends.
    do_clear();
    fill(16'h0000);
    cur_tab[0] = 16'h7FFF;
    cur_tab[1] = 16'h8000;
    run_step(16'h0001);
    check_mem("sat1_mem0", 0, 24575);
    check_mem("sat1_mem1", 1, -32768);
    cur_tab[1] = 16'h0000;
    run_step(16'h0001);
    stop();
    check_mem("sat2_mem0", 0, 24575);
    check_mem("sat2_mem1", 1, -29492);
    check("sat_seq_error", int'(seq_error), 0);

    // Skipped index and short step: error is sticky, spikes still publish.
    do_clear();
    beat(16'h1000, 0, 1'b0, 16'h0000);
    check("err_busy", int'(busy), 1);
    for (int i = 2; i < N; i++) beat(16'h1000, i, (i == N - 1), 16'h0000);
    stop();
    check("err_seq_error", int'(seq_error), 1);
    check("err_busy_after", int'(busy), 0);
    fill(16'h1000);
    run_step(16'h0000);
    stop();
    check("err_sticky", int'(seq_error), 1);
    do_clear();
    check("err_cleared", int'(seq_error), 0);

    // clear_state mid-stream with a simultaneous last beat.
    for (int i = 0; i < 5; i++) beat(16'h1000, i, 1'b0, 16'h0000);
    check("clr_busy_before", int'(busy), 1);
    bus.in_current = 16'h1000;
    bus.in_idx = 4'd5;
    bus.in_valid = 1'b1;
    bus.in_last = 1'b1;
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
    stop();
    check("clr_busy", int'(busy), 0);
    for (int i = 0; i < N; i++) check_mem("clr_mem", i, 0);
    repeat (2) @(negedge clk);
    fill(16'h1000);
    run_step(16'h0000);
    stop();
    check_mem("clr_step_mem0", 0, 4096);
    check_mem("clr_step_mem9", 9, 4096);

    // Neuron 3 fires, then async reset mid-stream.
    fill(16'h0000);
    cur_tab[3] = 16'h2000;
    run_step(16'h0008);
    stop();
    check("pre_rst_spikes", int'(spikes), 16'h0008);
    beat(16'h1000, 5, 1'b0, 16'h0000);
    stop();
    check("pre_rst_err", int'(seq_error), 1);
    check("pre_rst_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_spikes", int'(spikes), 0);
    check("arst_valid", int'(spikes_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_seq_error", int'(seq_error), 0);
    check_mem("arst_mem5", 5, 0);
`ifdef LIF_SPIKE_COUNT_EN
    check("arst_spike_count", int'(spike_count), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
